// File: rtl/dac_share_pkg.sv
// Shared types and default constants for the DAC sharing controller.
// Imported by the arbiter, the interface and the top level.
package dac_share_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } dac_state_t;

  localparam int DAC_DW         = 10;
  localparam int DAC_SETTLE_DEF = 4;
  localparam int DAC_CNT_DEF    = 16;

  // The settle counter is 8 bits wide because SETTLE_CYC tops out at 255.
  localparam int DAC_SETTLE_W   = 8;

  function automatic logic [DAC_SETTLE_W-1:0] settle_load(input int cycles);
    return DAC_SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dac_share_ctrl_if.sv
// Producer-side handshakes and DAC/debug outputs of the DAC sharing controller.
// The controller uses the slave modport; whoever drives the samples uses master.
interface dac_share_ctrl_if #(
  parameter int DW    = 10,
  parameter int CNT_W = 16
);
  logic             en;
  logic             req0_valid;
  logic [DW-1:0]    req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [DW-1:0]    req1_data;
  logic             req1_ready;
  logic [DW-1:0]    dac_code;
  logic             dac_en;
  logic             busy;
  logic             last_grant;
  logic [CNT_W-1:0] sample_cnt;

  modport slave (
    input  en, req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, dac_code, dac_en, busy, last_grant, sample_cnt
  );

  modport master (
    output en, req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, dac_code, dac_en, busy, last_grant, sample_cnt
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone request always wins, a tie goes to ptr.
// Purely combinational; the pointer is owned by the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);
endmodule

// File: rtl/dac_share_ctrl.sv
// Time-multiplexes one DAC between two sample producers: round-robin grant,
// registered code, then a fixed settling window before the next accept.
module dac_share_ctrl
  import dac_share_pkg::*;
#(
  parameter int DW         = DAC_DW,
  parameter int SETTLE_CYC = DAC_SETTLE_DEF,
  parameter int CNT_W      = DAC_CNT_DEF
) (
  input  logic            CLK,
  input  logic            reset,
  dac_share_ctrl_if.slave bus
);

  localparam logic [DAC_SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYC);

  dac_state_t              r_state;
  dac_state_t              w_state_next;
  logic [DAC_SETTLE_W-1:0] r_settle;
  logic [DW-1:0]           r_code;
  logic                    r_dac_en;
  logic                    r_last_grant;
  logic                    r_rr_ptr;
  logic [CNT_W-1:0]        r_sample_cnt;

  logic                    w_grant_ok;
  logic [1:0]              w_req;
  logic [1:0]              w_gnt;
  logic                    w_xfer;
  logic                    w_sel;
  logic [DW-1:0]           w_data;

  // Readies are held low while reset is asserted so no handshake is seen then.
  assign w_grant_ok = bus.en & (r_state == ST_IDLE) & ~reset;
  assign w_req      = {bus.req1_valid, bus.req0_valid} & {2{w_grant_ok}};

  rr_arb2 u_arb (
    .req (w_req),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  assign w_xfer = |w_gnt;
  assign w_sel  = w_gnt[1];
  assign w_data = w_sel ? bus.req1_data : bus.req0_data;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_settle     <= '0;
      r_code       <= '0;
      r_dac_en     <= 1'b0;
      r_last_grant <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_settle     <= SETTLE_LOAD;
        r_code       <= w_data;
        r_dac_en     <= 1'b1;
        r_last_grant <= w_sel;
        r_rr_ptr     <= ~w_sel;
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
        r_settle <= r_settle - 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];
  assign bus.dac_code   = r_code;
  assign bus.dac_en     = r_dac_en;
  assign bus.busy       = (r_state == ST_SETTLE);
  assign bus.last_grant = r_last_grant;
  assign bus.sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_dac_share_ctrl.sv
// Directed bench for dac_share_ctrl: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-window and sample counter wrap.
module tb_dac_share_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dac_share_ctrl_if #(.DW(10), .CNT_W(16)) bus0 ();
  dac_share_ctrl_if #(.DW(10), .CNT_W(4))  bus1 ();

  dac_share_ctrl #(.DW(10), .SETTLE_CYC(4), .CNT_W(16)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dac_share_ctrl #(.DW(10), .SETTLE_CYC(4), .CNT_W(4)) dut_w (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        v0;
    logic [9:0]  d0;
    logic        v1;
    logic [9:0]  d1;
    logic        r0;
    logic        r1;
    logic [9:0]  code;
    logic        den;
    logic        busy;
    logic        lg;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic rst, input logic en, input logic v0, input logic [9:0] d0,
    input logic v1, input logic [9:0] d1, input logic r0, input logic r1,
    input logic [9:0] code, input logic den, input logic busy, input logic lg,
    input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.code = code; v.den = den; v.busy = busy;
    v.lg = lg; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_n(input int n, input vec_t v);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    bit ok;

    bus0.en = 1'b0; bus0.req0_valid = 1'b0; bus0.req0_data = '0;
    bus0.req1_valid = 1'b0; bus0.req1_data = '0;
    bus1.en = 1'b0; bus1.req0_valid = 1'b0; bus1.req0_data = '0;
    bus1.req1_valid = 1'b0; bus1.req1_data = '0;

    // Single requester 0 with 3FF, then busy for four cycles.
    tbl.push_back(mk(0,1,1,10'h3FF,0,10'h000, 1,0,10'h000,0,0,0,0));
    push_n(4,     mk(0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,1,1,0,1));
    tbl.push_back(mk(0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,1,0,0,1));
    // Reset, then continuous contention: 100,200,101,201.
    tbl.push_back(mk(1,0,0,10'h000,0,10'h000, 0,0,10'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,10'h100,1,10'h200, 1,0,10'h000,0,0,0,0));
    push_n(4,     mk(0,1,1,10'h101,1,10'h200, 0,0,10'h100,1,1,0,1));
    tbl.push_back(mk(0,1,1,10'h101,1,10'h200, 0,1,10'h100,1,0,0,1));
    push_n(4,     mk(0,1,1,10'h101,1,10'h201, 0,0,10'h200,1,1,1,2));
    tbl.push_back(mk(0,1,1,10'h101,1,10'h201, 1,0,10'h200,1,0,1,2));
    push_n(4,     mk(0,1,1,10'h102,1,10'h201, 0,0,10'h101,1,1,0,3));
    tbl.push_back(mk(0,1,1,10'h102,1,10'h201, 0,1,10'h101,1,0,0,3));
    push_n(4,     mk(0,1,0,10'h000,0,10'h000, 0,0,10'h201,1,1,1,4));
    // req1 raises valid during a req0 window; accepted on first IDLE cycle.
    tbl.push_back(mk(0,1,1,10'h055,0,10'h000, 1,0,10'h201,1,0,1,4));
    push_n(4,     mk(0,1,0,10'h000,1,10'h0AA, 0,0,10'h055,1,1,0,5));
    tbl.push_back(mk(0,1,0,10'h000,1,10'h0AA, 0,1,10'h055,1,0,0,5));
    push_n(4,     mk(0,1,0,10'h000,0,10'h000, 0,0,10'h0AA,1,1,1,6));
    // en dropped mid-window with both valid; grant resumes to rr_ptr's pick.
    tbl.push_back(mk(0,1,1,10'h011,1,10'h022, 1,0,10'h0AA,1,0,1,6));
    tbl.push_back(mk(0,1,1,10'h012,1,10'h022, 0,0,10'h011,1,1,0,7));
    push_n(3,     mk(0,0,1,10'h012,1,10'h022, 0,0,10'h011,1,1,0,7));
    push_n(2,     mk(0,0,1,10'h012,1,10'h022, 0,0,10'h011,1,0,0,7));
    tbl.push_back(mk(0,1,1,10'h012,1,10'h022, 0,1,10'h011,1,0,0,7));
    push_n(4,     mk(0,1,1,10'h012,0,10'h000, 0,0,10'h022,1,1,1,8));
    tbl.push_back(mk(0,1,1,10'h012,0,10'h000, 1,0,10'h022,1,0,1,8));
    tbl.push_back(mk(0,1,0,10'h000,0,10'h000, 0,0,10'h012,1,1,0,9));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset           = tbl[i].rst;
      bus0.en         = tbl[i].en;
      bus0.req0_valid = tbl[i].v0;
      bus0.req0_data  = tbl[i].d0;
      bus0.req1_valid = tbl[i].v1;
      bus0.req1_data  = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d req0_ready", i), 32'(bus0.req0_ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d req1_ready", i), 32'(bus0.req1_ready), 32'(tbl[i].r1));
      chk($sformatf("v%0d dac_code",   i), 32'(bus0.dac_code),   32'(tbl[i].code));
      chk($sformatf("v%0d dac_en",     i), 32'(bus0.dac_en),     32'(tbl[i].den));
      chk($sformatf("v%0d busy",       i), 32'(bus0.busy),       32'(tbl[i].busy));
      chk($sformatf("v%0d last_grant", i), 32'(bus0.last_grant), 32'(tbl[i].lg));
      chk($sformatf("v%0d sample_cnt", i), 32'(bus0.sample_cnt), 32'(tbl[i].cnt));
      $display("vec %0d: code=%h cnt=%0d busy=%b", i, bus0.dac_code, bus0.sample_cnt, bus0.busy);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // Asynchronous reset in the middle of a 2AA settling window.
    bus0.en = 1'b1; bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (!bus0.busy) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("idle_wait", 32'(ok), 32'd1);
    bus0.req0_valid = 1'b1; bus0.req0_data = 10'h2AA;
    #1 chk("ar_req0_ready", 32'(bus0.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus0.req0_valid = 1'b0;
    @(negedge clk);
    chk("ar_code_2AA", 32'(bus0.dac_code), 32'h2AA);
    chk("ar_busy_pre", 32'(bus0.busy), 32'd1);
    chk("ar_lg_pre",   32'(bus0.last_grant), 32'd0);
    @(posedge clk); #3;
    bus0.req0_valid = 1'b1; bus0.req0_data = 10'h155;
    bus0.req1_valid = 1'b1; bus0.req1_data = 10'h0F0;
    #1 reset = 1'b1;
    #1;
    chk("ar_dac_code", 32'(bus0.dac_code),   32'd0);
    chk("ar_dac_en",   32'(bus0.dac_en),     32'd0);
    chk("ar_busy",     32'(bus0.busy),       32'd0);
    chk("ar_lg",       32'(bus0.last_grant), 32'd0);
    chk("ar_cnt",      32'(bus0.sample_cnt), 32'd0);
    chk("ar_r0_in_rst",32'(bus0.req0_ready), 32'd0);
    chk("ar_r1_in_rst",32'(bus0.req1_ready), 32'd0);
    $display("async reset: code=%h dac_en=%b busy=%b", bus0.dac_code, bus0.dac_en, bus0.busy);
    #1 reset = 1'b0;
    #1;
    chk("ar_post_r0", 32'(bus0.req0_ready), 32'd1);
    chk("ar_post_r1", 32'(bus0.req1_ready), 32'd0);
    @(posedge clk); #1;
    bus0.req0_valid = 1'b0;
    chk("ar_post_code", 32'(bus0.dac_code),   32'h155);
    chk("ar_post_den",  32'(bus0.dac_en),     32'd1);
    chk("ar_post_cnt",  32'(bus0.sample_cnt), 32'd1);
    $display("post reset accept: code=%h", bus0.dac_code);
    bus0.req1_valid = 1'b0;

    // Sample counter wrap with a 4-bit counter.
    bus1.en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      bus1.req0_valid = 1'b1;
      bus1.req0_data  = 10'(k);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        @(negedge clk);
        if (bus1.req0_ready) ok = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk($sformatf("wrap%0d_ready", k), 32'(ok), 32'd1);
      @(posedge clk); #1;
      bus1.req0_valid = 1'b0;
      chk($sformatf("wrap%0d_cnt",  k), 32'(bus1.sample_cnt), 32'(k % 16));
      chk($sformatf("wrap%0d_code", k), 32'(bus1.dac_code),   32'(k));
      $display("accept %0d: sample_cnt=%0d", k, bus1.sample_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dac_share_ctrl.md
# dac_share_ctrl

Time-multiplexes the SoC's single 10-bit DAC (avsddac) between two sample producers: the rvmyth core output (requester 0) and an auxiliary sample source such as a test-pattern or ramp generator (requester 1). The block sits between the producers and the DAC digital input in vsdbabysoc. It arbitrates round-robin, latches the granted code, and holds that code for a programmable settling window before accepting the next sample. It also reports grant ownership and a running sample count for debug.

## Interface
- DW, 10: DAC code width.
- SETTLE_CYC, 4: number of cycles a code is held after loading; legal range 1..255.
- CNT_W, 16: sample counter width.

- CLK  in  1  system clock (PLL output); all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  grant enable; when low, no new grants are issued.
- req0_valid  in  1  core sample valid.
- req0_data  in  DW  core sample code.
- req0_ready  out  1  core sample accepted this cycle.
- req1_valid  in  1  auxiliary sample valid.
- req1_data  in  DW  auxiliary sample code.
- req1_ready  out  1  auxiliary sample accepted this cycle.
- dac_code  out  DW  registered code driven to the DAC D input.
- dac_en  out  1  DAC output valid; 0 until the first sample loads, then sticky.
- busy  out  1  high during SETTLE.
- last_grant  out  1  index of the most recently served requester.
- sample_cnt  out  CNT_W  number of accepted samples; wraps.

## Operation
- State machine: IDLE and SETTLE.
- IDLE:
  - If en=1 and any valid is high, exactly one ready is asserted combinationally in the same cycle.
  - Selection when only one valid is high: that requester is chosen.
  - Selection when both valids are high: the requester named by rr_ptr is chosen.
- A transfer occurs when valid and ready are both high. On the next edge:
  - dac_code is set to the granted data.
  - dac_en is set to 1.
  - last_grant is set to the served index.
  - rr_ptr is set to the other index.
  - sample_cnt increments.
  - The settle counter is loaded with SETTLE_CYC-1.
  - The state moves to SETTLE.
- SETTLE:
  - Both readies are low.
  - If the counter is 0, the state returns to IDLE on the next edge. Otherwise the counter decrements.
- en=0:
  - In IDLE, no ready is asserted.
  - A SETTLE already in progress runs to completion.
- Producers must hold valid and data stable until accepted. The block never drops or duplicates a sample.
- sample_cnt wraps from 2^CNT_W-1 to 0 without any other side effect.
- Reset values: state IDLE, dac_code 0, dac_en 0, busy 0, last_grant 0, rr_ptr 0 (requester 0 preferred first), sample_cnt 0, readies 0.
- Reset mid-SETTLE:
  - Abandons the window immediately and clears dac_en.
  - The first sample after reset reloads the DAC normally.

## Timing
- Latency from accepted valid to dac_code changing: 1 cycle.
- busy rises in the same edge as the dac_code change.
- busy stays high for SETTLE_CYC cycles.
- Minimum spacing between consecutive accepts is SETTLE_CYC+1 cycles. With SETTLE_CYC=4, accepts can occur at cycles 0, 5, 10, …
- Under continuous contention, grants strictly alternate 0,1,0,1. Worst-case wait for a valid requester is 2·(SETTLE_CYC+1)−1 cycles.
- Ready depends only on state, en, valids and rr_ptr. There is no combinational path from data to ready.
- dac_code is glitch-free: it is a pure register.

## Structure
- Package dac_share_pkg contains:
  - the state enum (ST_IDLE, ST_SETTLE);
  - the default constants DAC_DW=10 and DAC_SETTLE_DEF=4.
- Sub-module rr_arb2 is a 2-input round-robin arbiter.
  - Inputs: req[1:0], ptr.
  - Output: one-hot gnt[1:0].
  - Purely combinational.
  - rr_ptr lives in the parent.
- Parent (dac_share_ctrl) contains: the FSM, the settle counter, the output registers and sample_cnt.

## Test plan
- Reset, then req0 valid with code 10'h3FF and req1 idle:
  - req0_ready is high in cycle 0;
  - dac_code=3FF and dac_en=1 in cycle 1;
  - busy is high for 4 cycles;
  - sample_cnt=1.
- Both valid continuously, req0 codes 100,101,… and req1 codes 200,201,…:
  - dac_code sequence is 100,200,101,201;
  - grants are spaced exactly 5 cycles apart;
  - last_grant toggles on each grant.
- req1 raises valid during SETTLE of a req0 sample:
  - req1_ready stays low until IDLE;
  - req1 is accepted on the first IDLE cycle, exactly 5 cycles after the req0 accept.
- en dropped mid-SETTLE with both valid:
  - the settle completes;
  - no ready while en=0;
  - the grant resumes on the cycle en returns high, going to rr_ptr's requester.
- reset asserted asynchronously mid-SETTLE with dac_code=2AA:
  - all outputs return to reset values immediately without waiting for CLK;
  - after reset release, the next accept is from req0 when both are valid.
- CNT_W=4, 17 accepts:
  - sample_cnt reads 15 after the 15th accept;
  - it wraps to 0 on the 16th;
  - it reads 1 after the 17th.
